set_bit_iterator: RTL and testbench

Parametrised sequential successor to the combinational lowest-set-bit index encoder. It accepts a WIDTH-bit vector over a valid/ready handshake. It then emits the index of every set bit, one per beat, in ascending order (LSB-first) or descending order (MSB-first), selected per vector. The block sits between request-mask producers (interrupt pending sets, free-slot bitmaps) and consumers that service one index at a time.

---
 rtl/set_bit_iterator.sv | 90 +++++++++
 tb/tb_set_bit_iterator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/set_bit_iterator.sv
// Sequential set-bit index iterator: accepts a bit vector over valid/ready and
// emits the index of every set bit, one per beat, LSB-first or MSB-first.
module set_bit_iterator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDXW  = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_msb_first,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDXW-1:0]   out_index,
    output logic [IDXW:0]     out_seq,
    output logic              out_last,
    output logic              out_none
);

    typedef enum logic {IDLE, ITER} state_t;

    localparam logic [IDXW:0] SEQ_ONE = 1;

    state_t             state;
    logic [WIDTH-1:0]   rem;
    logic               dir;
    logic               none;
    logic [WIDTH-1:0]   lowest;
    logic [IDXW-1:0]    lo_index;
    logic [IDXW-1:0]    hi_index;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == ITER);
    assign out_none  = none;

    assign lowest = rem & (~rem + WIDTH'(1));

    // lowest is one-hot (or zero), so OR-ing indices encodes it; for the
    // highest bit the ascending scan lets the last hit win.
    always_comb begin
        lo_index = '0;
        hi_index = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (lowest[i]) lo_index = lo_index | IDXW'(i);
            if (rem[i])    hi_index = IDXW'(i);
        end
    end

    always_comb begin
        out_index = '0;
        if (!none) out_index = dir ? hi_index : lo_index;
    end

    assign out_last = ((rem & (rem - WIDTH'(1))) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rem     <= '0;
            dir     <= 1'b0;
            out_seq <= '0;
            none    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem     <= in_data;
                        dir     <= in_msb_first;
                        out_seq <= '0;
                        none    <= (in_data == '0);
                        state   <= ITER;
                    end
                end
                ITER: begin
                    if (out_ready) begin
                        rem     <= rem & ~(WIDTH'(1) << out_index);
                        out_seq <= out_seq + SEQ_ONE;
                        if (out_last) begin
                            state <= IDLE;
                            none  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_set_bit_iterator.sv
// Randomized bench for set_bit_iterator (WIDTH=32 and WIDTH=5 instances)
// against a queue-based reference listing of expected beats per vector.
module tb_set_bit_iterator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_msb_first = 1'b0;
    logic        out_ready = 1'b0;

    logic        rdy32, val32, last32, none32;
    logic [4:0]  idx32;
    logic [5:0]  seq32;
    logic        rdy5, val5, last5, none5;
    logic [2:0]  idx5;
    logic [3:0]  seq5;

    logic        o_ready, o_valid, o_last, o_none;
    logic [31:0] o_index, o_seq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    set_bit_iterator #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & ~sel), .in_ready(rdy32),
        .in_data(in_data), .in_msb_first(in_msb_first),
        .out_valid(val32), .out_ready(out_ready & ~sel),
        .out_index(idx32), .out_seq(seq32),
        .out_last(last32), .out_none(none32)
    );

    set_bit_iterator #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & sel), .in_ready(rdy5),
        .in_data(in_data[4:0]), .in_msb_first(in_msb_first),
        .out_valid(val5), .out_ready(out_ready & sel),
        .out_index(idx5), .out_seq(seq5),
        .out_last(last5), .out_none(none5)
    );

    assign o_ready = sel ? rdy5  : rdy32;
    assign o_valid = sel ? val5  : val32;
    assign o_last  = sel ? last5 : last32;
    assign o_none  = sel ? none5 : none32;
    assign o_index = sel ? 32'(idx5) : 32'(idx32);
    assign o_seq   = sel ? 32'(seq5) : 32'(seq32);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with the selected DUT idle; returns at the negedge
    // after the final beat has transferred.
    task automatic run_vec(input logic [31:0] v, input logic dir,
                           input bit rand_ready, input bit scramble);
        int exp_q[$];
        int w = sel ? 5 : 32;
        int pos = 0;
        int cycles = 0;
        int n;
        logic [31:0] vm = v;
        if (sel) vm = v & 32'h1F;
        if (dir) begin
            for (int i = w - 1; i >= 0; i--) if (vm[i]) exp_q.push_back(i);
        end else begin
            for (int i = 0; i < w; i++) if (vm[i]) exp_q.push_back(i);
        end
        n = (exp_q.size() == 0) ? 1 : exp_q.size();

        check("idle_ready", o_ready, 1);
        check("idle_valid", o_valid, 0);
        in_valid = 1'b1;
        in_data = v;
        in_msb_first = dir;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("accept_valid", o_valid, 1);

        while (pos < n && cycles < 2000) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (scramble) begin
                in_data = $urandom;
                in_msb_first = 1'($urandom_range(0, 1));
                in_valid = 1'($urandom_range(0, 1));
            end
            check("iter_valid", o_valid, 1);
            check("iter_ready", o_ready, 0);
            if (exp_q.size() == 0) begin
                check("none_flag", o_none, 1);
                check("none_index", o_index, 0);
                check("none_seq", o_seq, 0);
                check("none_last", o_last, 1);
            end else begin
                check("none_flag", o_none, 0);
                check("index", o_index, 64'(exp_q[pos]));
                check("seq", o_seq, 64'(pos));
                check("last", o_last, (pos == n - 1) ? 1 : 0);
            end
            if (out_ready) pos++;
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("beat_budget", (cycles < 2000) ? 1 : 0, 1);
        check("done_ready", o_ready, 1);
        check("done_valid", o_valid, 0);
    endtask

    initial begin
        #12;
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_index", o_index, 0);
        check("rst_last", o_last, 1);
        check("rst_none", o_none, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_vec(32'h8000_0011, 1'b0, 1'b0, 1'b0);
        run_vec(32'h8000_0011, 1'b1, 1'b0, 1'b0);
        run_vec(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        run_vec(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
        run_vec(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);

        sel = 1'b1;
        run_vec(32'h0000_0012, 1'b1, 1'b0, 1'b0);
        run_vec(32'h0000_001F, 1'b0, 1'b1, 1'b0);
        run_vec(32'h0000_0000, 1'b1, 1'b1, 1'b0);
        sel = 1'b0;

        // Reset partway through 0xF0: two beats (4, 5) go out, then abandon.
        in_valid = 1'b1;
        in_data = 32'h0000_00F0;
        in_msb_first = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            check("pre_rst_index", o_index, 64'(b + 4));
            check("pre_rst_seq", o_seq, 64'(b));
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("pre_rst_valid", o_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_ready", o_ready, 1);
        check("mid_rst_index", o_index, 0);
        check("mid_rst_last", o_last, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", o_valid, 0);
        run_vec(32'h0000_0001, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] v;
            sel = 1'($urandom_range(0, 3) == 0);
            v = $urandom;
            if (t % 3 == 1) v = v & $urandom & $urandom;
            if (t % 7 == 3) v = '0;
            run_vec(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
